// File: rtl/turn_scheduler_if.sv
// Turn-controller bundle: player requests, datapath flags,
// write strobes, status and scores for the display decoders.
interface turn_scheduler_if;
  logic       restart;
  logic       p1_req;
  logic       p2_req;
  logic       inval;
  logic       win1;
  logic       win2;
  logic       draw;
  logic       enP1;
  logic       enP2;
  logic       turn;
  logic       LED_invalid;
  logic       timeout;
  logic       game_over;
  logic [3:0] move_cnt;
  logic [3:0] score1;
  logic [3:0] score2;

  modport master (
    output restart, p1_req, p2_req, inval, win1, win2, draw,
    input  enP1, enP2, turn, LED_invalid, timeout, game_over,
    input  move_cnt, score1, score2
  );

  modport slave (
    input  restart, p1_req, p2_req, inval, win1, win2, draw,
    output enP1, enP2, turn, LED_invalid, timeout, game_over,
    output move_cnt, score1, score2
  );
endinterface

// File: rtl/turn_scheduler.sv
// Tic-tac-toe turn controller: edge-detects move requests, grants
// write strobes, enforces a turn limit, counts moves, keeps scores.
// Ports: clock, reset (async, active-high), bus (slave modport).
module turn_scheduler #(
  parameter int TURN_LIMIT = 1000,
  parameter int TW         = 10,
  parameter int INVAL_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,
  turn_scheduler_if.slave   bus
);
  localparam int LW = $clog2(INVAL_HOLD + 1);

  typedef enum logic [1:0] {
    WAIT, WRITE, CHECK, OVER
  } state_t;

  state_t          state, next;
  logic            turn_q, starter;
  logic [TW-1:0]   timer;
  logic [3:0]      moves, s1, s2;
  logic [LW-1:0]   led_cnt;
  logic            p1_q, p2_q;
  logic            e1, e2, own;
  logic            take, reject, expire;

  assign e1  = bus.p1_req & ~p1_q;
  assign e2  = bus.p2_req & ~p2_q;
  assign own = turn_q ? e2 : e1;

  assign take   = (state == WAIT) & own & ~bus.inval;
  assign reject = (state == WAIT) & own & bus.inval;
  // an accepted edge in the expiry cycle beats the forfeit
  assign expire = (state == WAIT) & ~take & ~bus.restart
                & (timer == TW'(TURN_LIMIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WAIT;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      WAIT:  if (take) next = WRITE;
      WRITE: next = CHECK;
      CHECK: begin
        if (bus.win1 | bus.win2 | bus.draw | (moves == 4'd9))
          next = OVER;
        else
          next = WAIT;
      end
      OVER:  next = OVER;
      default: next = WAIT;
    endcase
    if (bus.restart) next = WAIT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      turn_q  <= 1'b0;
      starter <= 1'b0;
      timer   <= '0;
      moves   <= '0;
      s1      <= '0;
      s2      <= '0;
      led_cnt <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
    end else begin
      p1_q <= bus.p1_req;
      p2_q <= bus.p2_req;
      if (bus.restart) begin
        starter <= ~starter;
        turn_q  <= ~starter;
        timer   <= '0;
        moves   <= '0;
        led_cnt <= '0;
      end else begin
        case (state)
          WAIT: begin
            if (take) begin
              timer <= '0;
            end else if (expire) begin
              timer  <= '0;
              turn_q <= ~turn_q;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          WRITE: moves <= moves + 4'd1;
          CHECK: begin
            // win2 takes precedence if both flags are raised
            if (bus.win2) begin
              if (s2 != 4'd9) s2 <= s2 + 4'd1;
            end else if (bus.win1) begin
              if (s1 != 4'd9) s1 <= s1 + 4'd1;
            end else if (!bus.draw && moves != 4'd9) begin
              turn_q <= ~turn_q;
            end
          end
          default: ;
        endcase
        if (state == OVER)
          led_cnt <= '0;
        else if (reject)
          led_cnt <= LW'(INVAL_HOLD);
        else if (led_cnt != '0)
          led_cnt <= led_cnt - 1'b1;
      end
    end
  end

  assign bus.enP1        = (state == WRITE) & ~turn_q;
  assign bus.enP2        = (state == WRITE) & turn_q;
  assign bus.turn        = turn_q;
  assign bus.LED_invalid = (led_cnt != '0);
  assign bus.timeout     = expire;
  assign bus.game_over   = (state == OVER);
  assign bus.move_cnt    = moves;
  assign bus.score1      = s1;
  assign bus.score2      = s2;
endmodule

// File: tb/tb_turn_scheduler.sv
// Randomized scoreboard bench for turn_scheduler: a game-level
// model predicts strobe/timeout events and status after each action.
module tb_turn_scheduler;
  localparam int TL = 1000;
  localparam int IH = 4;

  logic clock;
  logic reset;
  int   cyc;
  int   n_pass;
  int   n_total;

  turn_scheduler_if bus();

  turn_scheduler #(
    .TURN_LIMIT(TL),
    .TW(10),
    .INVAL_HOLD(IH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int         c;
    logic [2:0] bits;
    int         mc;
  } ev_t;

  ev_t q[$];
  ev_t e;

  bit m_turn, m_starter, m_over;
  int m_moves, m_s1, m_s2, m_start;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  n, act, exp, cyc);
  endtask

  // monitor: every strobe/timeout must match the oldest prediction
  always @(negedge clock) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].c < cyc) begin
        e = q.pop_front();
        n_total++;
        $display("FAIL missed_event: bits %b due cycle %0d not seen",
                 e.bits, e.c);
      end
      if (bus.enP1 | bus.enP2 | bus.timeout) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_event: bits %b cycle %0d, none expected",
                   {bus.timeout, bus.enP2, bus.enP1}, cyc);
        end else begin
          e = q.pop_front();
          if (e.c == cyc && e.bits == {bus.timeout, bus.enP2, bus.enP1}
              && e.mc == int'(bus.move_cnt))
            n_pass++;
          else
            $display("FAIL event: got cyc %0d bits %b cnt %0d, expected cyc %0d bits %b cnt %0d",
                     cyc, {bus.timeout, bus.enP2, bus.enP1}, bus.move_cnt,
                     e.c, e.bits, e.mc);
        end
      end
    end
  end

  // close the current cycle; a turn forfeits on its last cycle
  // unless an accepted move or a restart lands there
  task automatic cycle_end(input bit acc, input bit rs);
    ev_t ev;
    if (!m_over && !acc && !rs && cyc == m_start + TL - 1) begin
      ev.c = cyc; ev.bits = 3'b100; ev.mc = m_moves;
      q.push_back(ev);
      m_turn  = !m_turn;
      m_start = cyc + 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_end(0, 0);
  endtask

  task automatic idle_until(input int k);
    while (cyc < k) cycle_end(0, 0);
  endtask

  task automatic status();
    chk("turn", bus.turn, m_turn);
    chk("move_cnt", bus.move_cnt, m_moves);
    chk("game_over", bus.game_over, m_over);
    chk("score1", bus.score1, m_s1);
    chk("score2", bus.score2, m_s2);
  endtask

  task automatic do_move(input bit [1:0] who, input bit iv,
                         input bit w1, input bit w2, input bit dr);
    ev_t ev;
    bit  own, acc;
    int  k;
    k   = cyc;
    own = m_turn ? who[1] : who[0];
    acc = !m_over && own && !iv;
    bus.p1_req = who[0]; bus.p2_req = who[1]; bus.inval = iv;
    bus.win1 = w1; bus.win2 = w2; bus.draw = dr;
    if (acc) begin
      ev.c = k + 1; ev.bits = m_turn ? 3'b010 : 3'b001; ev.mc = m_moves;
      q.push_back(ev);
      m_moves++;
      if (w2) begin
        if (m_s2 < 9) m_s2++;
        m_over = 1;
      end else if (w1) begin
        if (m_s1 < 9) m_s1++;
        m_over = 1;
      end else if (dr || m_moves == 9) begin
        m_over = 1;
      end else begin
        m_turn = !m_turn;
      end
      m_start = k + 3;
    end
    cycle_end(acc, 0);
    bus.p1_req = 0; bus.p2_req = 0; bus.inval = 0;
    cycle_end(0, 0);
    cycle_end(0, 0);
    bus.win1 = 0; bus.win2 = 0; bus.draw = 0;
    status();
  endtask

  task automatic do_restart();
    bus.restart = 1;
    m_starter = !m_starter;
    m_turn    = m_starter;
    m_moves   = 0;
    m_over    = 0;
    m_start   = cyc + 1;
    cycle_end(0, 1);
    bus.restart = 0;
    status();
    chk("led_after_restart", bus.LED_invalid, 0);
  endtask

  task automatic model_reset();
    m_turn = 0; m_starter = 0; m_over = 0;
    m_moves = 0; m_s1 = 0; m_s2 = 0;
    m_start = cyc;
  endtask

  task automatic reset_outputs();
    chk("rst_enP1", bus.enP1, 0);
    chk("rst_enP2", bus.enP2, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_led", bus.LED_invalid, 0);
    chk("rst_turn", bus.turn, 0);
    chk("rst_game_over", bus.game_over, 0);
    chk("rst_move_cnt", bus.move_cnt, 0);
    chk("rst_score1", bus.score1, 0);
    chk("rst_score2", bus.score2, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, r;
    ev_t ev;
    n_pass = 0; n_total = 0; cyc = 0;
    reset = 1;
    bus.restart = 0; bus.p1_req = 0; bus.p2_req = 0; bus.inval = 0;
    bus.win1 = 0; bus.win2 = 0; bus.draw = 0;
    repeat (3) @(posedge clock);
    #1;
    reset_outputs();
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();

    // rejected move: LED for exactly IH cycles, no strobe
    bus.p1_req = 1; bus.inval = 1;
    cycle_end(0, 0);
    bus.p1_req = 0; bus.inval = 0;
    for (int i = 1; i <= IH + 1; i++) begin
      chk("led_hold", bus.LED_invalid, (i <= IH) ? 1 : 0);
      cycle_end(0, 0);
    end
    chk("turn_after_inval", bus.turn, 0);
    // off-turn request: ignored, no LED
    bus.p2_req = 1;
    cycle_end(0, 0);
    bus.p2_req = 0;
    chk("led_offturn", bus.LED_invalid, 0);
    cycle_end(0, 0);

    // idle turn forfeits
    idle_until(m_start + TL);
    status();
    chk("turn_after_timeout", bus.turn, 1);

    // accepted edge on the expiry cycle wins over the forfeit
    idle_until(m_start + TL - 1);
    do_move(2'b10, 0, 0, 0, 0);
    do_move(2'b01, 0, 0, 0, 0);

    // player 1 wins, later edges ignored, restart keeps score
    do_move(2'b10, 0, 0, 0, 0);
    do_move(2'b01, 0, 1, 0, 0);
    do_move(2'b01, 0, 0, 0, 0);
    do_move(2'b10, 0, 0, 0, 0);
    idle(5);
    do_restart();
    chk("restart_turn", bus.turn, 1);

    // asynchronous reset mid-game
    do_move(2'b10, 0, 0, 0, 0);
    #3;
    reset = 1;
    #1;
    reset_outputs();
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();

    // restart in the strobe cycle discards the move
    k = cyc;
    bus.p1_req = 1;
    ev.c = k + 1; ev.bits = 3'b001; ev.mc = 0;
    q.push_back(ev);
    cycle_end(1, 0);
    bus.p1_req = 0;
    do_restart();
    idle(2);
    status();

    // player 2 score saturates at 9
    for (int i = 0; i < 10; i++) begin
      do_restart();
      if (!m_turn) do_move(2'b01, 0, 0, 0, 0);
      do_move(2'b10, 0, 0, 1, 0);
    end
    chk("score2_sat", bus.score2, 9);

    // nine moves without a result end the game
    do_restart();
    for (int i = 0; i < 9; i++)
      do_move(m_turn ? 2'b10 : 2'b01, 0, 0, 0, 0);
    chk("nine_over", bus.game_over, 1);

    // randomized play
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (m_over) begin
        if (r < 70) do_restart();
        else do_move(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                     0, 0, 0);
      end else begin
        idle($urandom_range(0, 12));
        if (r < 3) begin
          idle(TL);
        end else if (r < 60) begin
          do_move(m_turn ? 2'b10 : 2'b01, 0,
                  $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 4);
        end else if (r < 75) begin
          do_move(m_turn ? 2'b10 : 2'b01, 1, 0, 0, 0);
        end else if (r < 85) begin
          do_move(m_turn ? 2'b01 : 2'b10, 0, 0, 0, 0);
        end else if (r < 95) begin
          do_move(2'b11, 0, $urandom_range(0, 99) < 10, 0, 0);
        end else begin
          do_restart();
        end
      end
    end

    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
